seg_scan_controller: RTL

Time-division scan controller for the multi-digit seven-segment display. It owns the digit-select timing, accepts new display values through a valid/ready handshake, and commits them atomically at frame boundaries so no frame shows mixed old and new digits. It optionally inserts an all-digits-off blanking interval between digits to suppress ghosting. It sits between the value source (DIP switches or an upstream block) and the seven-segment decoder and anode drivers.

---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg_dwell_timer.sv | 39 +++
 rtl/seg_scan_controller.sv | 115 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and defaults for the seven-segment scan controller.
// Optional blanking between digits is built when SEG_SCAN_BLANK_EN is defined.
package seg_pkg;

    typedef enum logic {
        StBlank,
        StShow
    } scan_state_t;

    typedef logic [3:0] nibble_t;

    localparam int unsigned DefNumDigits   = 2;
    localparam int unsigned DefDwellCycles = 65536;
    localparam int unsigned DefBlankCycles = 256;

    // Counter width that holds the longer of the two phase lengths.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/seg_dwell_timer.sv
// Loadable phase down-counter; expire_o marks the final count of a phase.
module seg_dwell_timer
    import seg_pkg::*;
#(
    parameter int unsigned         CntW     = 8,
    parameter logic [CntW-1:0]     ResetVal = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    output logic            expire_o
);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Reload at phase change, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= ResetVal;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/seg_scan_controller.sv
// Time-division digit scanner with valid/ready value loading and
// frame-boundary commit. Define SEG_SCAN_BLANK_EN to insert an all-off
// blanking phase before every digit.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = DefNumDigits,
    parameter int unsigned DWELL_CYCLES = DefDwellCycles,
    parameter int unsigned BLANK_CYCLES = DefBlankCycles
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output nibble_t                 nibble_out,
    output logic                    frame_done
);

    localparam int unsigned IdxW = $clog2(NUM_DIGITS);
    localparam int unsigned CntW = cnt_width(DWELL_CYCLES, BLANK_CYCLES);

    localparam logic [CntW-1:0]       DwellLoad = CntW'(DWELL_CYCLES - 1);
    localparam logic [IdxW-1:0]       LastIdx   = IdxW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] OneHot0   = NUM_DIGITS'(1);

`ifdef SEG_SCAN_BLANK_EN
    localparam logic [CntW-1:0]       BlankLoad  = CntW'(BLANK_CYCLES - 1);
    localparam logic [CntW-1:0]       ResetLoad  = BlankLoad;
    localparam scan_state_t           ResetState = StBlank;
    localparam logic [NUM_DIGITS-1:0] ResetEn    = '0;
`else
    localparam logic [CntW-1:0]       ResetLoad  = DwellLoad;
    localparam scan_state_t           ResetState = StShow;
    localparam logic [NUM_DIGITS-1:0] ResetEn    = OneHot0;
`endif

    scan_state_t             state_q;
    logic [IdxW-1:0]         idx_q;
    logic [4*NUM_DIGITS-1:0] active_q;
    logic [4*NUM_DIGITS-1:0] pending_q;
    logic                    pend_full_q;
    logic [NUM_DIGITS-1:0]   digit_en_q;

    logic                    expire;
    logic [CntW-1:0]         load_val;
    logic [IdxW-1:0]         idx_next;
    logic                    frame_end;

    // Next index, frame-end detect and reload value for the upcoming phase.
    always_comb begin
        idx_next  = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
        frame_end = (state_q == StShow) && (idx_q == LastIdx) && expire;
`ifdef SEG_SCAN_BLANK_EN
        load_val  = (state_q == StShow) ? BlankLoad : DwellLoad;
`else
        load_val  = DwellLoad;
`endif
    end

    // Single shared timer; reloaded on every phase expiry.
    seg_dwell_timer #(
        .CntW     (CntW),
        .ResetVal (ResetLoad)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (expire),
        .load_val_i (load_val),
        .expire_o   (expire)
    );

    // Scan FSM, handshake buffer and frame-boundary commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ResetState;
            idx_q       <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            pend_full_q <= 1'b0;
            digit_en_q  <= ResetEn;
        end else begin
            if (expire) begin
`ifdef SEG_SCAN_BLANK_EN
                if (state_q == StShow) begin
                    state_q    <= StBlank;
                    idx_q      <= idx_next;
                    digit_en_q <= '0;
                end else begin
                    state_q    <= StShow;
                    digit_en_q <= OneHot0 << idx_q;
                end
`else
                idx_q      <= idx_next;
                digit_en_q <= OneHot0 << idx_next;
`endif
            end
            // Commit needs pend_full, accept needs !pend_full: never both.
            if (frame_end && pend_full_q) begin
                active_q    <= pending_q;
                pend_full_q <= 1'b0;
            end else if (load_valid && !pend_full_q) begin
                pending_q   <= load_data;
                pend_full_q <= 1'b1;
            end
        end
    end

    assign digit_en   = digit_en_q;
    assign nibble_out = active_q[4*idx_q +: 4];
    assign load_ready = !pend_full_q;
    assign frame_done = frame_end;

endmodule
